conv_wload: RTL and testbench
=============================

Name: conv_wload

Overview:
- Weight-load sequencer sitting directly upstream of the 25-tap conv weight shift register.
- On a start pulse, reads 25 consecutive words (one 5x5 kernel) from the weight memory, starting at a given base address.
- Drives the shift register's write-enable and data so that, when done, weight0 holds mem[base] and weight24 holds mem[base+24].
- Signals completion to the conv controller.

Parameters:
- DWIDTH, 16, weight word width (matches shift-register data width).
- AWIDTH, 12, weight memory address width.
- FSIZE, 5, kernel side; words per load = FSIZE*FSIZE = 25.
- RD_LAT, 1, weight memory read latency in cycles (legal range 1..4).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  load request pulse, sampled when idle
- base_addr  in  AWIDTH  kernel base address, captured with start
- mem_re  out  1  memory read enable
- mem_addr  out  AWIDTH  memory read address
- mem_rdata  in  DWIDTH  signed memory read data, valid RD_LAT cycles after mem_re
- wreg_we  out  1  shift enable to weight register
- read_data  out  DWIDTH  signed data to weight register; combinational pass-through of mem_rdata
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: mem_re=0, mem_addr=0, wreg_we=0, busy=0, done=0; state=IDLE; counters=0.
- All state is registered on posedge clk or async clear on rst.
- States:
  - IDLE: on start=1, latch base_addr; go to ISSUE.
  - ISSUE: mem_re=1, mem_addr=base+cnt, cnt 0..24. When cnt==24, go to DRAIN.
  - DRAIN: wait until the last read returns, i.e. RD_LAT cycles after the final mem_re. The cycle after the last wreg_we, go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- Timing, with start sampled at edge 0:
  - mem_re high in cycles 1..25 with addresses base..base+24.
  - wreg_we high in cycles 1+RD_LAT..25+RD_LAT; exactly 25 pulses, contiguous, no gaps.
  - done high in cycle 26+RD_LAT.
  - busy high from cycle 1 through 25+RD_LAT; low in the DONE cycle.
- wreg_we is mem_re delayed by an RD_LAT-deep registered valid pipeline. It is not derived from state, so data alignment is exact for any RD_LAT.
- Address arithmetic is modulo 2^AWIDTH: base=2^AWIDTH-3 reads top-3, top-2, top-1, 0, 1, ... No error flag.
- start while busy or in DONE is ignored; it is neither queued nor allowed to alter the latched base. A new start is accepted in IDLE only, so back-to-back loads have a one-cycle gap after done.
- base_addr changes after the start cycle have no effect.
- rst mid-load:
  - All outputs clear immediately (asynchronously). Pending reads in flight are discarded, so no wreg_we follows reset.
  - The weight register then holds a partial kernel; the controller must reload.
- read_data is a pure wire from mem_rdata. It may be X when wreg_we=0; the downstream register ignores it then.

Decomposition:
- Shared parameters include (existing DWIDTH file): add FSIZE, and WCOUNT = FSIZE*FSIZE.
- FSM state encodings live as localparams inside the module.
- No sub-module. The RD_LAT valid delay line is a small generate loop inside conv_wload.

Test Plan:
- Basic load, RD_LAT=1: memory holds mem[100+i]=i-12; start with base=100 → mem_addr 100..124 in cycles 1..25, wreg_we in cycles 2..26, done in cycle 27. Downstream register shows weight0=-12, weight12=0, weight24=12.
- Latency sweep RD_LAT=1,2,4: same memory image → exactly 25 wreg_we pulses each time, done at cycle 26+RD_LAT, identical final weights.
- Address wrap, AWIDTH=12: base=4090 → addresses 4090..4095 then 0..18; weight6=mem[0].
- Start during busy: start at cycle 0 (base=0), then start at cycle 10 (base=500) → no address ≥500 issued, a single done, weights from base 0.
- Back-to-back: second start in the cycle after done, with base=200 → second load completes normally; weights then equal mem[200..224].
- Reset mid-load: assert rst in cycle 12 for 2 cycles → mem_re, wreg_we, busy, done all 0 from the rst edge and with no later wreg_we. A subsequent start with base=100 loads a full, correct kernel.

Source files
------------

// File: rtl/conv_wload_pkg.sv
// rtl/conv_wload_pkg.sv - shared widths and kernel geometry for the conv weight-load path
package conv_wload_pkg;

  localparam int DEF_DWIDTH = 16;
  localparam int DEF_AWIDTH = 12;
  localparam int DEF_FSIZE  = 5;

  // words in one square kernel
  function automatic int kernel_words(input int fsize);
    return fsize * fsize;
  endfunction

  localparam int DEF_WCOUNT = kernel_words(DEF_FSIZE);

endpackage

// File: rtl/conv_wload.sv
// rtl/conv_wload.sv - kernel weight-load sequencer feeding the conv weight shift register
module conv_wload
  import conv_wload_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int FSIZE  = DEF_FSIZE,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              wreg_we,
  output logic [DWIDTH-1:0] read_data,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS = kernel_words(FSIZE);
  localparam int CW     = $clog2(NWORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [AWIDTH-1:0] base_q;
  logic [RD_LAT-1:0] vld;
  logic              reads_behind;

  // Data goes straight through; the register only looks at it when wreg_we is high.
  assign read_data = mem_rdata;
  assign wreg_we   = vld[RD_LAT-1];
  assign cnt_inc   = cnt + CW'(1);
  // Any read still travelling behind the one currently at the output tap.
  assign reads_behind = |(vld << 1);

  // Valid delay line: each read's valid bit reaches wreg_we in the cycle its data arrives.
  for (genvar i = 0; i < RD_LAT; i++) begin : g_vld
    if (i == 0) begin : g_head
      // first stage samples the read strobe
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld[0] <= 1'b0;
        else     vld[0] <= mem_re;
      end
    end else begin : g_tail
      // later stages age the valid bit by one cycle each
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld[i] <= 1'b0;
        else     vld[i] <= vld[i-1];
      end
    end
  end

  // Sequencer: issue one kernel of reads, wait for the last return, then pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      base_q   <= '0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            cnt      <= '0;
            mem_re   <= 1'b1;
            mem_addr <= base_addr;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt == CW'(NWORDS - 1)) begin
            mem_re <= 1'b0;
            state  <= S_DRAIN;
          end else begin
            cnt      <= cnt_inc;
            mem_addr <= base_q + AWIDTH'(cnt_inc);
          end
        end
        S_DRAIN: begin
          // final word is being written now and nothing else is in flight
          if (wreg_we && !reads_behind) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_wload.sv
// tb/tb_conv_wload.sv - scoreboard bench for conv_wload at read latencies 1, 2 and 4
module tb_conv_wload;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int NW = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  // expected-load log: stimulus appends, each lane monitor consumes with its own pointer
  int log_base [32];
  int log_cyc  [32];
  int nlog      = 0;
  bit finishing = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory image: mem[100+i] = i-12
  function automatic logic signed [DW-1:0] memval(input int a);
    return DW'(a - 112);
  endfunction

  task automatic chk(input bit ok, input string name, input int lat, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s (RD_LAT=%0d): got %0d, expected %0d", name, lat, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

    logic                 mem_re, wreg_we, busy, done;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_rdata, read_data;
    logic [DW-1:0]        pd [4];
    logic signed [DW-1:0] w  [NW];
    int ptr = 0;
    int nrd = 0;
    int nwe = 0;
    bit active   = 1'b0;
    bit reported = 1'b0;

    conv_wload #(.DWIDTH(DW), .AWIDTH(AW), .FSIZE(5), .RD_LAT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .wreg_we   (wreg_we),
      .read_data (read_data),
      .busy      (busy),
      .done      (done)
    );

    assign mem_rdata = pd[L-1];

    // memory with L-cycle read latency, plus the downstream 25-tap shift register
    always @(posedge clk) begin
      pd[0] <= mem_re ? memval(int'(mem_addr)) : 16'h7BAD;
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
      if (wreg_we) begin
        for (int i = 0; i < NW - 1; i++) w[i] <= w[i+1];
        w[NW-1] <= read_data;
      end
    end

    always @(negedge clk) begin
      int rel;
      int bad;
      if (rst) begin
        chk({mem_re, wreg_we, busy, done} == 4'b0 && mem_addr == '0, "reset_outputs", L,
            int'({mem_re, wreg_we, busy, done}), 0);
        if (active) begin
          active = 1'b0;
          ptr++;
        end
      end else begin
        if (!active && ptr < nlog && cyc > log_cyc[ptr]) begin
          active = 1'b1;
          nrd    = 0;
          nwe    = 0;
        end
        if (!active) begin
          chk({mem_re, wreg_we, busy, done} == 4'b0, "idle_quiet", L,
              int'({mem_re, wreg_we, busy, done}), 0);
          if (finishing && !reported) begin
            reported = 1'b1;
            chk(ptr == nlog, "all_loads_done", L, ptr, nlog);
          end
        end else begin
          rel = cyc - log_cyc[ptr];
          if (mem_re) begin
            chk(rel == nrd + 1, "read_cycle", L, rel, nrd + 1);
            chk(mem_addr == AW'(log_base[ptr] + nrd), "read_addr", L, int'(mem_addr),
                (log_base[ptr] + nrd) % 4096);
            nrd++;
          end
          if (wreg_we) begin
            chk(rel == nwe + 1 + L, "we_cycle", L, rel, nwe + 1 + L);
            nwe++;
          end
          chk(busy == (rel <= 25 + L), "busy", L, int'(busy), int'(rel <= 25 + L));
          if (done) begin
            chk(rel == 26 + L, "done_cycle", L, rel, 26 + L);
            chk(nrd == NW, "read_count", L, nrd, NW);
            chk(nwe == NW, "we_count", L, nwe, NW);
            bad = 0;
            for (int i = 0; i < NW; i++)
              if (w[i] != memval((log_base[ptr] + i) % 4096)) bad++;
            chk(bad == 0, "weights", L, bad, 0);
            if (log_base[ptr] == 100) begin
              chk(w[0]  == -12, "weight0_base100",  L, int'(w[0]),  -12);
              chk(w[12] == 0,   "weight12_base100", L, int'(w[12]), 0);
              chk(w[24] == 12,  "weight24_base100", L, int'(w[24]), 12);
            end
            if (log_base[ptr] == 4090) begin
              chk(w[5] == 3983, "weight5_wrap", L, int'(w[5]), 3983);
              chk(w[6] == -112, "weight6_wrap", L, int'(w[6]), -112);
            end
            active = 1'b0;
            ptr++;
          end else if (rel > 26 + L) begin
            chk(1'b0, "done_timeout", L, rel, 26 + L);
            active = 1'b0;
            ptr++;
          end
        end
      end
    end
  end

  // one load request; optional ignored start and optional reset pulse at given load-relative cycles
  task automatic load(input int base, input int ign_rel, input int ign_base, input int rst_rel);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(base);
    log_base[nlog] = base;
    log_cyc[nlog]  = cyc;
    nlog++;
    for (int r = 1; r <= 30; r++) begin
      @(posedge clk); #1;
      start     = (r == ign_rel);
      base_addr = (r == ign_rel) ? AW'(ign_base) : 12'hABC;
      rst       = (rst_rel >= 0) && (r == rst_rel || r == rst_rel + 1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    load(100,  -1, 0,   -1);
    load(0,    10, 500, -1);
    load(200,  -1, 0,   -1);
    load(4090, -1, 0,   -1);
    load(50,   -1, 0,   12);
    repeat (3) @(posedge clk);
    load(100,  -1, 0,   -1);

    repeat (4) @(posedge clk);
    #1 finishing = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
